rectfill_queue: RTL and testbench

//  Queued rectangle-fill engine; parametrised successor to the single-rect background fill client.

---
 rtl/rectfill_pkg.sv | 28 ++
 rtl/rectfill_queue_cmd_fifo.sv | 53 +++++
 rtl/rectfill_queue.sv | 177 +++++++++++++++++
 tb/tb_rectfill_queue.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/rectfill_pkg.sv
// Shared types for the queued rectangle-fill engine.
// Optional feature macro: RECTFILL_CHECKER_EN (adds a second checker colour per command).
package rectfill_pkg;

  localparam int unsigned RF_XW = 10;
  localparam int unsigned RF_YW = 10;
  localparam int unsigned RF_DN = 16;

  // Field widths follow the package widths; the top's XW/YW/DN default to these.
  typedef struct packed {
    logic [RF_XW-1:0] x;
    logic [RF_YW-1:0] y;
    logic [RF_XW-1:0] w;
    logic [RF_YW-1:0] h;
    logic [RF_DN-1:0] colour;
`ifdef RECTFILL_CHECKER_EN
    logic [RF_DN-1:0] colour2;
`endif
  } rect_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FILL,
    DONE
  } fill_state_t;

endpackage

// File: rtl/rectfill_queue_cmd_fifo.sv
// Generic synchronous FIFO (registered storage, full/empty flags).
module cmd_fifo #(
  parameter type         T     = logic,
  parameter int unsigned DEPTH = 4
) (
  input  logic clkSYS,
  input  logic reset,
  input  logic wr_en,
  input  T     wr_data,
  input  logic rd_en,
  output T     rd_data,
  output logic full,
  output logic empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = rd_en & ~empty;
  assign do_push = wr_en & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clkSYS) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clkSYS) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rectfill_queue.sv
// Queued rectangle-fill engine: buffers fill commands and writes each pixel
// through one write-only arbiter port. Optional macro: RECTFILL_CHECKER_EN.
module rectfill_queue
  import rectfill_pkg::*;
#(
  parameter int unsigned   AN    = 24,
  parameter int unsigned   DN    = RF_DN,
  parameter logic [AN-1:0] BASE  = 24'hfa0000,
  parameter int unsigned   LS    = 800,
  parameter int unsigned   XW    = RF_XW,
  parameter int unsigned   YW    = RF_YW,
  parameter int unsigned   DEPTH = 4
) (
  input  logic          clkSYS,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [XW-1:0] cmd_x,
  input  logic [YW-1:0] cmd_y,
  input  logic [XW-1:0] cmd_w,
  input  logic [YW-1:0] cmd_h,
  input  logic [DN-1:0] cmd_colour,
`ifdef RECTFILL_CHECKER_EN
  input  logic [DN-1:0] cmd_colour2,
`endif
  output logic [AN-1:0] req_addr,
  output logic [DN-1:0] req_data,
  output logic          req,
  output logic          req_wr,
  input  logic          req_ack,
  output logic          busy,
  output logic          done
);

  localparam logic [AN-1:0] LS_A = AN'(LS);

  fill_state_t   state;
  fill_state_t   state_nxt;
  rect_cmd_t     push_data;
  rect_cmd_t     head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic [AN-1:0] addr;
  logic [AN-1:0] row;
  logic [AN-1:0] row_calc;
  logic [XW-1:0] cols;
  logic [XW-1:0] w_reg;
  logic [YW-1:0] lines;
  logic [DN-1:0] colour;
  logic          last_col;
  logic          last_line;
`ifdef RECTFILL_CHECKER_EN
  logic [DN-1:0] colour2;
  logic          col_odd;
  logic          line_odd;
`endif

  // Pack the offered command into a FIFO record.
  always_comb begin
    push_data        = '0;
    push_data.x      = cmd_x;
    push_data.y      = cmd_y;
    push_data.w      = cmd_w;
    push_data.h      = cmd_h;
    push_data.colour = cmd_colour;
`ifdef RECTFILL_CHECKER_EN
    push_data.colour2 = cmd_colour2;
`endif
  end

  cmd_fifo #(
    .T     (rect_cmd_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clkSYS  (clkSYS),
    .reset   (reset),
    .wr_en   (cmd_valid & cmd_ready),
    .wr_data (push_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign cmd_ready = ~fifo_full;
  assign row_calc  = BASE + AN'(head.y) * LS_A + AN'(head.x);
  assign last_col  = (cols == XW'(1));
  assign last_line = (lines == YW'(1));
  assign req       = (state == FILL);
  assign req_wr    = 1'b1;
  assign req_addr  = addr;
  assign busy      = (state != IDLE) | ~fifo_empty;

`ifdef RECTFILL_CHECKER_EN
  assign req_data = (col_odd ^ line_odd) ? colour2 : colour;
`else
  assign req_data = colour;
`endif

  // State register.
  always_ff @(posedge clkSYS) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state, FIFO pop and retire pulse.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: if (!fifo_empty) state_nxt = LOAD;
      LOAD: begin
        pop       = 1'b1;
        state_nxt = (head.w == '0 || head.h == '0) ? DONE : FILL;
      end
      FILL: if (req_ack && last_col && last_line) state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = fifo_empty ? IDLE : LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address/count datapath: one multiply at load, then incremental line steps.
  always_ff @(posedge clkSYS) begin
    if (reset) begin
      addr   <= '0;
      row    <= '0;
      cols   <= '0;
      w_reg  <= '0;
      lines  <= '0;
      colour <= '0;
`ifdef RECTFILL_CHECKER_EN
      colour2  <= '0;
      col_odd  <= 1'b0;
      line_odd <= 1'b0;
`endif
    end else begin
      if (state == LOAD) begin
        addr   <= row_calc;
        row    <= row_calc;
        cols   <= head.w;
        w_reg  <= head.w;
        lines  <= head.h;
        colour <= head.colour;
`ifdef RECTFILL_CHECKER_EN
        colour2  <= head.colour2;
        col_odd  <= 1'b0;
        line_odd <= 1'b0;
`endif
      end else if (state == FILL && req_ack) begin
        if (last_col) begin
          if (!last_line) begin
            lines <= lines - YW'(1);
            row   <= row + LS_A;
            addr  <= row + LS_A;
            cols  <= w_reg;
`ifdef RECTFILL_CHECKER_EN
            col_odd  <= 1'b0;
            line_odd <= ~line_odd;
`endif
          end
        end else begin
          addr <= addr + AN'(1);
          cols <= cols - XW'(1);
`ifdef RECTFILL_CHECKER_EN
          col_odd <= ~col_odd;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_rectfill_queue.sv
// Self-checking bench for rectfill_queue (BASE=0, LS=800, DEPTH=4).
module tb_rectfill_queue;

  logic        clkSYS = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_x, cmd_y, cmd_w, cmd_h;
  logic [15:0] cmd_colour;
  logic [15:0] cmd_colour2;
  logic [23:0] req_addr;
  logic [15:0] req_data;
  logic        req, req_wr, req_ack, busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clkSYS = ~clkSYS;

  rectfill_queue #(
    .AN(24), .DN(16), .BASE(24'h000000), .LS(800), .XW(10), .YW(10), .DEPTH(4)
  ) dut (
    .clkSYS      (clkSYS),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_x       (cmd_x),
    .cmd_y       (cmd_y),
    .cmd_w       (cmd_w),
    .cmd_h       (cmd_h),
    .cmd_colour  (cmd_colour),
`ifdef RECTFILL_CHECKER_EN
    .cmd_colour2 (cmd_colour2),
`endif
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req         (req),
    .req_wr      (req_wr),
    .req_ack     (req_ack),
    .busy        (busy),
    .done        (done)
  );

  typedef struct {
    string       name;
    logic [9:0]  x, y, w, h;
    logic [15:0] c, c2;
    int          div;
    logic [23:0] base;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input logic [9:0] x, y, w, h, input logic [15:0] c, c2);
    int t;
    @(negedge clkSYS);
    cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h;
    cmd_colour = c; cmd_colour2 = c2;
    cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 200) begin
      @(negedge clkSYS);
      t++;
    end
    chk("push_accept", 32'(t < 200), 32'd1);
    @(negedge clkSYS);
    cmd_valid = 1'b0;
  endtask

  task automatic run_rect(input vec_t v);
    int widx, dcnt, cyc, first_done, i, j;
    logic [23:0] ea;
    logic [15:0] ed;
    logic        bad_req;
    push_cmd(v.x, v.y, v.w, v.h, v.c, v.c2);
    widx = 0; dcnt = 0; cyc = 0; first_done = -1; bad_req = 1'b0;
    for (int c = 0; c < 300 && dcnt == 0; c++) begin
      @(negedge clkSYS);
      if (done) begin
        dcnt++;
        first_done = c;
      end
      if (req && v.w == 0) begin
        bad_req = 1'b1;
        req_ack = 1'b1;
      end else if (req) begin
        i  = widx % int'(v.w);
        j  = widx / int'(v.w);
        ea = v.base + 24'(j * 800 + i);
`ifdef RECTFILL_CHECKER_EN
        ed = (((i ^ j) & 1) != 0) ? v.c2 : v.c;
`else
        ed = v.c;
`endif
        chk({v.name, "_addr"}, 32'(req_addr), 32'(ea));
        chk({v.name, "_data"}, 32'(req_data), 32'(ed));
        req_ack = ((cyc % v.div) == v.div - 1);
        cyc++;
        if (req_ack) widx++;
      end else begin
        req_ack = 1'b0;
      end
    end
    req_ack = 1'b0;
    chk({v.name, "_done_cnt"}, 32'(dcnt), 32'd1);
    chk({v.name, "_writes"}, 32'(widx), 32'(int'(v.w) * int'(v.h)));
    chk({v.name, "_req_empty"}, 32'(bad_req), 32'd0);
    if (v.w == 0 || v.h == 0) chk({v.name, "_done_latency"}, 32'(first_done <= 2), 32'd1);
    @(negedge clkSYS);
    chk({v.name, "_done_pulse"}, 32'(done), 32'd0);
    chk({v.name, "_busy_fall"}, 32'(busy), 32'd0);
    chk({v.name, "_req_low"}, 32'(req), 32'd0);
  endtask

  task automatic wait_req(input string name);
    int t;
    t = 0;
    while (!req && t < 50) begin
      @(negedge clkSYS);
      t++;
    end
    chk(name, 32'(req), 32'd1);
  endtask

  initial begin
    int writes, dones, first_done, acc, seen_req, seen_done;
    logic fired;

    vt[0] = '{"r4x2_ack1",  10'd2,   10'd3,  10'd4, 10'd2, 16'hF800, 16'h07FF, 1, 24'd2402};
    vt[1] = '{"r4x2_ack3",  10'd2,   10'd3,  10'd4, 10'd2, 16'hF800, 16'h07FF, 3, 24'd2402};
    vt[2] = '{"r1x1",       10'd0,   10'd0,  10'd1, 10'd1, 16'h1234, 16'hEDCB, 1, 24'd0};
    vt[3] = '{"r3x1_wrap",  10'd799, 10'd1,  10'd3, 10'd1, 16'h07E0, 16'hF81F, 2, 24'd1599};
    vt[4] = '{"w0",         10'd0,   10'd5,  10'd0, 10'd5, 16'hFFFF, 16'h0000, 1, 24'd0};
    vt[5] = '{"h0",         10'd5,   10'd0,  10'd3, 10'd0, 16'hFFFF, 16'h0000, 1, 24'd0};
    vt[6] = '{"r2x2",       10'd10,  10'd10, 10'd2, 10'd2, 16'hAAAA, 16'h5555, 1, 24'd8010};

    reset = 1'b1; cmd_valid = 1'b0; req_ack = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_colour = '0; cmd_colour2 = '0;
    repeat (3) @(negedge clkSYS);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_addr", 32'(req_addr), 32'd0);
    chk("rst_data", 32'(req_data), 32'd0);
    chk("req_wr", 32'(req_wr), 32'd1);
    reset = 1'b0;

    for (int k = 0; k < 7; k++) run_rect(vt[k]);

    // Queue fills while the active rect is stalled; fifth command waits for a pop.
    push_cmd(10'd4, 10'd1, 10'd4, 10'd4, 16'h0F0F, 16'hF0F0);
    wait_req("q_first_req");
    for (int k = 0; k < 4; k++) push_cmd(10'(10 * k), 10'd2, 10'd2, 10'd1, 16'h1111, 16'h2222);
    cmd_x = 10'd50; cmd_y = 10'd3; cmd_w = 10'd2; cmd_h = 10'd1;
    cmd_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clkSYS);
      chk("q_full_ready", 32'(cmd_ready), 32'd0);
      chk("q_hold_addr", 32'(req_addr), 32'd804);
    end
    fired = 1'b0; writes = 0; dones = 0; first_done = -1; acc = -1;
    for (int c = 0; c < 400 && dones < 6; c++) begin
      @(negedge clkSYS);
      if (fired) cmd_valid = 1'b0;
      fired = cmd_valid && cmd_ready;
      if (fired) acc = c;
      if (done) begin
        dones++;
        if (first_done < 0) first_done = c;
      end
      req_ack = req;
      if (req) writes++;
    end
    req_ack = 1'b0;
    cmd_valid = 1'b0;
    chk("q_dones", 32'(dones), 32'd6);
    chk("q_writes", 32'(writes), 32'd26);
    chk("q_accept_after_pop", 32'(acc), 32'(first_done + 2));
    @(negedge clkSYS);
    chk("q_busy_fall", 32'(busy), 32'd0);

    // Reset while filling word 3 of a 4x4 rect with two commands queued.
    push_cmd(10'd0, 10'd0, 10'd4, 10'd4, 16'hBEEF, 16'h0000);
    wait_req("r_first_req");
    push_cmd(10'd1, 10'd1, 10'd2, 10'd2, 16'h1111, 16'h0000);
    push_cmd(10'd2, 10'd2, 10'd2, 10'd2, 16'h2222, 16'h0000);
    req_ack = 1'b1;
    repeat (2) @(negedge clkSYS);
    req_ack = 1'b0;
    chk("r_word3_addr", 32'(req_addr), 32'd2);
    reset = 1'b1;
    @(negedge clkSYS);
    chk("r_req", 32'(req), 32'd0);
    chk("r_busy", 32'(busy), 32'd0);
    chk("r_ready", 32'(cmd_ready), 32'd1);
    chk("r_addr", 32'(req_addr), 32'd0);
    reset = 1'b0;
    seen_req = 0; seen_done = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clkSYS);
      if (req) seen_req++;
      if (done) seen_done++;
    end
    chk("r_no_req", 32'(seen_req), 32'd0);
    chk("r_no_done", 32'(seen_done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
